// File: rtl/reset_sequencer.sv
`default_nettype none
// reset_sequencer: merges key/PLL/software reset causes, stretches, then releases domains in order.
// Optional sticky cause capture (rst_cause, rst_cause_clr) when RST_CAUSE_EN is defined.
module reset_sequencer #(
  parameter int N_DOMAINS       = 3,
  parameter int STRETCH_CYCLES  = 1024,
  parameter int STAGE_GAP       = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 rst_async,
  input  logic                 key_n,
  input  logic                 pll_locked,
  input  logic                 sw_rst_req,
`ifdef RST_CAUSE_EN
  input  logic                 rst_cause_clr,
  output logic [2:0]           rst_cause,
`endif
  output logic [N_DOMAINS-1:0] rst_out,
  output logic                 seq_done
);

  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int STR_W   = $clog2(STRETCH_CYCLES + 1);
  localparam int GAP_W   = $clog2(STAGE_GAP + 1);
  localparam int STAGE_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  localparam logic [DEB_W-1:0]     DEB_MAX    = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [STR_W-1:0]     STR_LAST   = STR_W'(STRETCH_CYCLES - 1);
  localparam logic [GAP_W-1:0]     GAP_LAST   = GAP_W'(STAGE_GAP - 1);
  localparam logic [STAGE_W-1:0]   STAGE_LAST = STAGE_W'(N_DOMAINS - 1);
  localparam logic [N_DOMAINS-1:0] FIRST_BIT  = N_DOMAINS'(1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  logic             key_meta, key_s;
  logic             lock_meta, lock_s;
  logic [DEB_W-1:0] deb_cnt;
  logic             key_pressed;
  logic             cause;

  // Key idles high and PLL idles unlocked, so reset leaves both as "no press, not locked".
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      key_meta  <= 1'b1;
      key_s     <= 1'b1;
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      key_meta  <= key_n;
      key_s     <= key_meta;
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      deb_cnt <= '0;
    end else if (key_s) begin
      deb_cnt <= '0;
    end else if (deb_cnt != DEB_MAX) begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign key_pressed = !key_s && (deb_cnt == DEB_MAX);
  assign cause       = key_pressed | ~lock_s | sw_rst_req;

  state_t               state, state_nxt;
  logic [STR_W-1:0]     cnt, cnt_nxt;
  logic [GAP_W-1:0]     gap, gap_nxt;
  logic [STAGE_W-1:0]   stage, stage_nxt;
  logic [N_DOMAINS-1:0] rst_nxt;
  logic                 done_nxt;

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state    <= ST_HOLD;
      cnt      <= '0;
      gap      <= '0;
      stage    <= '0;
      rst_out  <= '1;
      seq_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      gap      <= gap_nxt;
      stage    <= stage_nxt;
      rst_out  <= rst_nxt;
      seq_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gap_nxt   = gap;
    stage_nxt = stage;
    rst_nxt   = rst_out;
    done_nxt  = seq_done;

    unique case (state)
      ST_HOLD: begin
        rst_nxt   = '1;
        done_nxt  = 1'b0;
        cnt_nxt   = '0;
        gap_nxt   = '0;
        stage_nxt = '0;
        if (!cause) state_nxt = ST_STRETCH;
      end
      ST_STRETCH: begin
        if (cnt == STR_LAST) begin
          state_nxt = ST_RELEASE;
          stage_nxt = '0;
          gap_nxt   = '0;
          rst_nxt   = rst_out & ~FIRST_BIT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (gap == GAP_LAST) begin
          if (stage == STAGE_LAST) begin
            state_nxt = ST_RUN;
            done_nxt  = 1'b1;
          end else begin
            // Lower bits are already clear, so masking one more bit keeps release ordered.
            stage_nxt = stage + 1'b1;
            rst_nxt   = rst_out & ~(FIRST_BIT << (32'(stage) + 32'd1));
            gap_nxt   = '0;
          end
        end else begin
          gap_nxt = gap + 1'b1;
        end
      end
      ST_RUN: begin
        rst_nxt  = '0;
        done_nxt = 1'b1;
      end
    endcase

    // A cause anywhere past HOLD aborts the sequence; the next release restarts the stretch.
    if (cause && (state != ST_HOLD)) begin
      state_nxt = ST_HOLD;
      rst_nxt   = '1;
      done_nxt  = 1'b0;
      cnt_nxt   = '0;
      gap_nxt   = '0;
      stage_nxt = '0;
    end
  end

`ifdef RST_CAUSE_EN
  logic [2:0] cause_terms;
  assign cause_terms = {sw_rst_req, key_pressed, ~lock_s};

  // A cause arriving together with a clear still gets recorded.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      rst_cause <= 3'b000;
    end else if (rst_cause_clr) begin
      rst_cause <= cause_terms;
    end else begin
      rst_cause <= rst_cause | cause_terms;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// tb_reset_sequencer: directed scenarios plus random cause traffic against a run-length reference model.
module tb_reset_sequencer;

  localparam int N = 3;
  localparam int S = 8;
  localparam int G = 4;
  localparam int D = 5;

  logic         clk = 1'b0;
  logic         rst_async;
  logic         key_n;
  logic         pll_locked;
  logic         sw_rst_req;
  logic [N-1:0] rst_out;
  logic         seq_done;
`ifdef RST_CAUSE_EN
  logic         rst_cause_clr;
  logic [2:0]   rst_cause;
  logic [2:0]   cause_m;
`endif

  always #5 clk = ~clk;

  reset_sequencer #(
    .N_DOMAINS      (N),
    .STRETCH_CYCLES (S),
    .STAGE_GAP      (G),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk          (clk),
    .rst_async    (rst_async),
    .key_n        (key_n),
    .pll_locked   (pll_locked),
    .sw_rst_req   (sw_rst_req),
`ifdef RST_CAUSE_EN
    .rst_cause_clr(rst_cause_clr),
    .rst_cause    (rst_cause),
`endif
    .rst_out      (rst_out),
    .seq_done     (seq_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: outputs depend only on how many consecutive edges saw no reset cause.
  int   run_len;
  int   key_low_len;
  logic key_q[$];
  logic pll_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [N-1:0] exp_rst(input int n);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (n < S + 1 + i * G);
    return v;
  endfunction

  function automatic logic exp_done(input int n);
    return n >= S + 1 + N * G;
  endfunction

  task automatic model_reset();
    run_len     = 0;
    key_low_len = 0;
    key_q       = {};
    pll_q       = {};
    key_q.push_back(1'b1);
    key_q.push_back(1'b1);
    pll_q.push_back(1'b0);
    pll_q.push_back(1'b0);
`ifdef RST_CAUSE_EN
    cause_m = 3'b000;
`endif
  endtask

  task automatic model_edge();
    logic ks, ls, pressed, c;
    ks      = key_q[0];
    ls      = pll_q[0];
    pressed = !ks && (key_low_len >= D);
    c       = pressed || !ls || sw_rst_req;
`ifdef RST_CAUSE_EN
    if (rst_cause_clr) cause_m = {sw_rst_req, pressed, !ls};
    else               cause_m = cause_m | {sw_rst_req, pressed, !ls};
`endif
    run_len     = c ? 0 : ((run_len < 100000) ? run_len + 1 : run_len);
    key_low_len = ks ? 0 : ((key_low_len < 100000) ? key_low_len + 1 : key_low_len);
    void'(key_q.pop_front());
    key_q.push_back(key_n);
    void'(pll_q.pop_front());
    pll_q.push_back(pll_locked);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_rst"}, 32'(rst_out), 32'(exp_rst(run_len)));
    check({tag, "_done"}, 32'(seq_done), 32'(exp_done(run_len)));
`ifdef RST_CAUSE_EN
    check({tag, "_cause"}, 32'(rst_cause), 32'(cause_m));
`endif
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model(tag);
  endtask

  // Release sequence after causes clear two edges into the run (sync latency).
  task automatic release_seq(input string tag);
    for (int k = 1; k <= 24; k++) begin
      tick(tag);
      if (k == 10) check({tag, "_k10"}, 32'(rst_out), 32'(3'b111));
      if (k == 11) check({tag, "_k11"}, 32'(rst_out), 32'(3'b110));
      if (k == 15) check({tag, "_k15"}, 32'(rst_out), 32'(3'b100));
      if (k == 19) check({tag, "_k19"}, 32'(rst_out), 32'(3'b000));
      if (k == 22) check({tag, "_k22"}, 32'(seq_done), 32'(1'b0));
      if (k == 23) check({tag, "_k23"}, 32'(seq_done), 32'(1'b1));
    end
  endtask

  task automatic async_pulse(input string tag);
    #2 rst_async = 1'b1;
    #1;
    model_reset();
    check({tag, "_rst"}, 32'(rst_out), 32'(3'b111));
    check({tag, "_done"}, 32'(seq_done), 32'(1'b0));
    #1 rst_async = 1'b0;
  endtask

  initial begin
    int pll_lo_left;
    int key_lo_left;
    rst_async  = 1'b1;
    key_n      = 1'b1;
    pll_locked = 1'b1;
    sw_rst_req = 1'b0;
`ifdef RST_CAUSE_EN
    rst_cause_clr = 1'b0;
`endif
    #1;
    check("reset_rst", 32'(rst_out), 32'(3'b111));
    check("reset_done", 32'(seq_done), 32'(1'b0));
    repeat (2) @(negedge clk);
    check("reset_hold", 32'(rst_out), 32'(3'b111));
    model_reset();
    rst_async = 1'b0;

    // Power-up sequence
    release_seq("s1");

    // PLL loss in RUN, then relock
    pll_locked = 1'b0;
    tick("s2a");
    tick("s2b");
    check("s2_before", 32'(rst_out), 32'(3'b000));
    tick("s2c");
    check("s2_loss_rst", 32'(rst_out), 32'(3'b111));
    check("s2_loss_done", 32'(seq_done), 32'(1'b0));
    pll_locked = 1'b1;
    release_seq("s2r");

    // Short key press ignored, long press resets
    key_n = 1'b0;
    repeat (4) tick("s3s");
    key_n = 1'b1;
    repeat (10) tick("s3q");
    check("s3_short", 32'(rst_out), 32'(3'b000));
    key_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick("s3l");
      if (k == 7) check("s3_k7", 32'(rst_out), 32'(3'b000));
      if (k == 8) check("s3_k8", 32'(rst_out), 32'(3'b111));
    end
    key_n = 1'b1;
    repeat (40) tick("s3r");
    check("s3_run", 32'(seq_done), 32'(1'b1));

    // Software request aborts a release in progress
    sw_rst_req = 1'b1;
    tick("s4p");
    sw_rst_req = 1'b0;
    repeat (9) tick("s4a");
    check("s4_bit0", 32'(rst_out), 32'(3'b110));
    repeat (2) tick("s4b");
    sw_rst_req = 1'b1;
    tick("s4c");
    check("s4_abort", 32'(rst_out), 32'(3'b111));
    sw_rst_req = 1'b0;
    repeat (8) tick("s4d");
    check("s4_stretch", 32'(rst_out), 32'(3'b111));
    tick("s4e");
    check("s4_rerelease", 32'(rst_out), 32'(3'b110));
    repeat (15) tick("s4f");

    // Asynchronous reset mid-release
    sw_rst_req = 1'b1;
    tick("s5p");
    sw_rst_req = 1'b0;
    repeat (11) tick("s5a");
    async_pulse("s5");
    release_seq("s5r");

`ifdef RST_CAUSE_EN
    rst_cause_clr = 1'b1;
    tick("s6c0");
    rst_cause_clr = 1'b0;
    check("s6_clr0", 32'(rst_cause), 32'(3'b000));
    pll_locked = 1'b0;
    repeat (3) tick("s6l");
    pll_locked = 1'b1;
    repeat (3) tick("s6m");
    sw_rst_req = 1'b1;
    tick("s6s");
    sw_rst_req = 1'b0;
    check("s6_101", 32'(rst_cause), 32'(3'b101));
    rst_cause_clr = 1'b1;
    tick("s6c1");
    check("s6_clr", 32'(rst_cause), 32'(3'b000));
    sw_rst_req = 1'b1;
    tick("s6c2");
    rst_cause_clr = 1'b0;
    sw_rst_req    = 1'b0;
    check("s6_win", 32'(rst_cause), 32'(3'b100));
    repeat (24) tick("s6r");
`endif

    // Random cause traffic
    pll_lo_left = 0;
    key_lo_left = 0;
    for (int c = 0; c < 1500; c++) begin
      if (pll_lo_left == 0 && $urandom_range(0, 299) == 0) pll_lo_left = int'($urandom_range(1, 6));
      if (key_lo_left == 0 && $urandom_range(0, 149) == 0) key_lo_left = int'($urandom_range(1, 12));
      pll_locked = (pll_lo_left == 0);
      key_n      = (key_lo_left == 0);
      if (pll_lo_left > 0) pll_lo_left--;
      if (key_lo_left > 0) key_lo_left--;
      sw_rst_req = ($urandom_range(0, 199) == 0);
`ifdef RST_CAUSE_EN
      rst_cause_clr = ($urandom_range(0, 49) == 0);
`endif
      if ($urandom_range(0, 999) == 0) async_pulse("rnd_async");
      tick("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
